// File: rtl/clk_en_gen_pkg.sv
// Shared state encoding and divisor constants for the clock-enable generator.
package clk_en_gen_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // 1 Hz strobe from the 100 MHz board clock.
    localparam int unsigned BoardDefaultDiv = 100000000;

    // Small divisors that keep simulation runs short.
    localparam int unsigned BenchDefaultDiv = 4;
    localparam int unsigned BenchBurstDiv   = 3;
    localparam int unsigned BenchFastDiv    = 2;

endpackage

// File: rtl/clk_en_gen_mod_counter.sv
// Modulo counter: counts 0..modulus-1 while enabled, flags the terminal value.
module clk_en_gen_mod_counter #(
    parameter int unsigned CNT_W = 27
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] modulus_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        // >= rather than == so a stale count above the modulus still wraps.
        tc_o    = count_q >= (modulus_i - 1'b1);
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = tc_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/clk_en_gen.sv
// Programmable clock-enable strobe generator with continuous and burst modes.
module clk_en_gen
    import clk_en_gen_pkg::*;
#(
    parameter int unsigned CNT_W       = 27,
    parameter int unsigned DEFAULT_DIV = BoardDefaultDiv,
    parameter int unsigned BURST_W     = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               stop,
    input  logic               div_load,
    input  logic [CNT_W-1:0]   div_in,
    input  logic [BURST_W-1:0] burst_len,
    output logic               clk_en,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   div_cur
);

    state_e               state_q, state_d;
    logic                 clk_en_q, clk_en_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [CNT_W-1:0]     div_cur_q, div_cur_d;
    logic [CNT_W-1:0]     pend_div_q, pend_div_d;
    logic                 pend_vld_q, pend_vld_d;
    logic [BURST_W-1:0]   pulse_q, pulse_d;
    logic [BURST_W-1:0]   burst_q, burst_d;
    logic [BURST_W-1:0]   pulse_inc;
    logic                 load_ok;
    logic                 run;
    logic                 tc;

    assign run = (state_q == StRun);

    clk_en_gen_mod_counter #(
        .CNT_W (CNT_W)
    ) u_period (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr_i     (!run || stop),
        .en_i      (run),
        .modulus_i (div_cur_q),
        .tc_o      (tc)
    );

    always_comb begin
        state_d    = state_q;
        clk_en_d   = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        div_cur_d  = div_cur_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        pulse_d    = pulse_q;
        burst_d    = burst_q;
        pulse_inc  = pulse_q + 1'b1;
        load_ok    = div_load && (div_in != '0);

        unique case (state_q)
            StIdle: begin
                if (load_ok) begin
                    div_cur_d = div_in;
                end
                if (start && !stop) begin
                    state_d = StRun;
                    busy_d  = 1'b1;
                    pulse_d = '0;
                    burst_d = burst_len;
                end
            end
            StRun: begin
                if (load_ok) begin
                    pend_vld_d = 1'b1;
                    pend_div_d = div_in;
                end
                if (stop) begin
                    state_d    = StIdle;
                    busy_d     = 1'b0;
                    pend_vld_d = 1'b0;
                    if (load_ok) begin
                        div_cur_d = div_in;
                    end else if (pend_vld_q) begin
                        div_cur_d = pend_div_q;
                    end
                end else if (tc) begin
                    clk_en_d = 1'b1;
                    pulse_d  = pulse_inc;
                    // The period just ending used the old divisor; the new one starts now.
                    if (pend_vld_q) begin
                        div_cur_d  = pend_div_q;
                        pend_vld_d = load_ok;
                    end
                    if ((burst_q != '0) && (pulse_inc == burst_q)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d    = StIdle;
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pend_vld_d = 1'b0;
                if (load_ok) begin
                    div_cur_d = div_in;
                end else if (pend_vld_q) begin
                    div_cur_d = pend_div_q;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            clk_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_cur_q  <= CNT_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            pulse_q    <= '0;
            burst_q    <= '0;
        end else begin
            state_q    <= state_d;
            clk_en_q   <= clk_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            div_cur_q  <= div_cur_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            pulse_q    <= pulse_d;
            burst_q    <= burst_d;
        end
    end

    assign clk_en  = clk_en_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign div_cur = div_cur_q;

endmodule

// File: tb/tb_clk_en_gen.sv
// Directed bench for clk_en_gen using small divisors; cycle t is the interval after edge t.
module tb_clk_en_gen;

    localparam int unsigned CNT_W   = 27;
    localparam int unsigned BURST_W = 16;
    localparam int unsigned DEF_DIV = 4;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic               stop;
    logic               div_load;
    logic [CNT_W-1:0]   div_in;
    logic [BURST_W-1:0] burst_len;
    logic               clk_en;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   div_cur;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    clk_en_gen #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .BURST_W     (BURST_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .div_load  (div_load),
        .div_in    (div_in),
        .burst_len (burst_len),
        .clk_en    (clk_en),
        .busy      (busy),
        .done      (done),
        .div_cur   (div_cur)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one edge and settle; inputs driven afterwards are sampled at the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        div_load  = 1'b0;
        div_in    = '0;
        burst_len = '0;
        tick();
        tick();
        chk_cnt++;
        if ({clk_en, busy, done} !== 3'b000) $display("FAIL reset_outs got %b want 000", {clk_en, busy, done});
        else pass_cnt++;
        chk_cnt++;
        if (div_cur !== CNT_W'(DEF_DIV)) $display("FAIL reset_div got %0d want %0d", div_cur, DEF_DIV);
        else pass_cnt++;
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_continuous();
        logic exp_en;
        start     = 1'b1;
        burst_len = '0;
        for (int t = 1; t <= 24; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            exp_en = (t >= 5) && (((t - 5) % 4) == 0);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL cont_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== 1'b1) $display("FAIL cont_busy t=%0d got %b want 1", t, busy);
            else pass_cnt++;
            chk_cnt++;
            if (done !== 1'b0) $display("FAIL cont_done t=%0d got %b want 0", t, done);
            else pass_cnt++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_cnt++;
        if ({busy, done} !== 2'b00) $display("FAIL cont_stop got %b want 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_burst();
        logic exp_en, exp_busy, exp_done;
        div_in   = CNT_W'(3);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        chk_cnt++;
        if (div_cur !== CNT_W'(3)) $display("FAIL burst_load got %0d want 3", div_cur);
        else pass_cnt++;
        burst_len = BURST_W'(3);
        start     = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            exp_en   = (t == 4) || (t == 7) || (t == 10);
            exp_busy = (t <= 10);
            exp_done = (t == 11);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL burst_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== exp_busy) $display("FAIL burst_busy t=%0d got %b want %b", t, busy, exp_busy);
            else pass_cnt++;
            chk_cnt++;
            if (done !== exp_done) $display("FAIL burst_done t=%0d got %b want %b", t, done, exp_done);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_change();
        logic             exp_en;
        logic [CNT_W-1:0] exp_div;
        div_in   = CNT_W'(4);
        div_load = 1'b1;
        tick();
        div_load  = 1'b0;
        burst_len = '0;
        start     = 1'b1;
        for (int t = 1; t <= 20; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            if (t == 10) begin
                div_in   = CNT_W'(2);
                div_load = 1'b1;
            end
            if (t == 11) div_load = 1'b0;
            exp_en  = (t == 5) || (t == 9) || (t == 13) || (t == 15) || (t == 17) || (t == 19);
            exp_div = (t >= 13) ? CNT_W'(2) : CNT_W'(4);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL chg_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
            chk_cnt++;
            if (div_cur !== exp_div) $display("FAIL chg_div t=%0d got %0d want %0d", t, div_cur, exp_div);
            else pass_cnt++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_cnt++;
        if ({clk_en, busy} !== 2'b00) $display("FAIL chg_stop got %b want 00", {clk_en, busy});
        else pass_cnt++;
    endtask

    task automatic test_stop_terminal();
        logic exp_en, exp_busy;
        div_in   = CNT_W'(4);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        start    = 1'b1;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            if (t == 8) stop = 1'b1;
            if (t == 9) stop = 1'b0;
            exp_en   = (t == 5);
            exp_busy = (t <= 8);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL stop_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== exp_busy) $display("FAIL stop_busy t=%0d got %b want %b", t, busy, exp_busy);
            else pass_cnt++;
            chk_cnt++;
            if (done !== 1'b0) $display("FAIL stop_done t=%0d got %b want 0", t, done);
            else pass_cnt++;
        end
        start = 1'b1;
        for (int t = 1; t <= 10; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            exp_en = (t == 5) || (t == 9);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL restart_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic test_idle_loads();
        logic exp_en;
        div_in   = '0;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        chk_cnt++;
        if (div_cur !== CNT_W'(4)) $display("FAIL zero_load got %0d want 4", div_cur);
        else pass_cnt++;
        div_in   = CNT_W'(1);
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        chk_cnt++;
        if (div_cur !== CNT_W'(1)) $display("FAIL one_load got %0d want 1", div_cur);
        else pass_cnt++;
        start = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            exp_en = (t >= 2);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL div1_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
            chk_cnt++;
            if (busy !== 1'b1) $display("FAIL div1_busy t=%0d got %b want 1", t, busy);
            else pass_cnt++;
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        chk_cnt++;
        if ({clk_en, busy} !== 2'b00) $display("FAIL div1_stop got %b want 00", {clk_en, busy});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        logic exp_en;
        div_in   = CNT_W'(3);
        div_load = 1'b1;
        tick();
        div_load  = 1'b0;
        burst_len = BURST_W'(5);
        start     = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            if (t == 1) start = 1'b0;
            if (t == 8) reset_n = 1'b0;
            exp_en = (t == 4) || (t == 7);
            chk_cnt++;
            if (clk_en !== exp_en) $display("FAIL rmid_en t=%0d got %b want %b", t, clk_en, exp_en);
            else pass_cnt++;
        end
        tick();
        reset_n = 1'b1;
        chk_cnt++;
        if ({clk_en, busy, done} !== 3'b000) $display("FAIL rmid_outs got %b want 000", {clk_en, busy, done});
        else pass_cnt++;
        chk_cnt++;
        if (div_cur !== CNT_W'(DEF_DIV)) $display("FAIL rmid_div got %0d want %0d", div_cur, DEF_DIV);
        else pass_cnt++;
        for (int t = 10; t <= 25; t++) begin
            tick();
            chk_cnt++;
            if ({clk_en, busy, done} !== 3'b000) $display("FAIL rmid_quiet t=%0d got %b want 000", t, {clk_en, busy, done});
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_burst();
        test_div_change();
        test_stop_terminal();
        test_idle_loads();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
